// File: rtl/wb_pkg.sv
// Shared encodings and stage-register control bundle
// for the MEM/WB writeback stage.
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic       valid;
        logic       fresh;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
        logic [4:0] rd_addr;
    } wb_ctrl_t;

endpackage

// File: rtl/load_extend.sv
// Extracts, aligns and sign/zero-extends a load field
// from a 64-bit doubleword, flagging misaligned accesses.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh         = rdata >> {off, 3'b000};
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB: data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH: begin
                data       = {{(XLEN-16){sh[15]}}, sh[15:0]};
                misaligned = off[0];
            end
            F3_LW: begin
                data       = {{(XLEN-32){sh[31]}}, sh[31:0]};
                misaligned = |off[1:0];
            end
            F3_LD: begin
                data       = sh;
                misaligned = |off;
            end
            F3_LBU: data = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, sh[15:0]};
                misaligned = off[0];
            end
            F3_LWU: begin
                data       = {{(XLEN-32){1'b0}}, sh[31:0]};
                misaligned = |off[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback mux and
// retired-instruction counter.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_reg_write,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [XLEN-1:0] in_pc,
    output logic            reg_write,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            load_misaligned,
    output logic [63:0]     retired_count
);

    wb_ctrl_t        ctrl_q, ctrl_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdata_q, mdata_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [63:0]     count_q, count_d;

    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            mis;
    logic            live;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata      (mdata_q),
        .off        (alu_q[2:0]),
        .funct3     (ctrl_q.funct3),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    // fresh limits each instruction to one write/count across stalls
    assign live = ctrl_q.valid && ctrl_q.fresh;
    assign mis  = (ctrl_q.wb_sel == WB_MEM) && ld_mis;

    assign reg_write = live && ctrl_q.reg_write
                     && (ctrl_q.rd_addr != 5'd0) && !mis;
    assign load_misaligned = live && mis;
    assign rd_addr         = ctrl_q.rd_addr;
    assign retired_count   = count_q;

    always_comb begin
        case (ctrl_q.wb_sel)
            WB_ALU:  rd_data = alu_q;
            WB_MEM:  rd_data = ld_data;
            WB_PC4:  rd_data = pc_q + XLEN'(4);
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        mdata_d = mdata_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (live && !mis) begin
            count_d = count_q + 64'd1;
        end
        if (rst) begin
            ctrl_d  = '0;
            alu_d   = '0;
            mdata_d = '0;
            pc_d    = '0;
            count_d = '0;
        end else if (flush) begin
            ctrl_d.valid = 1'b0;
            ctrl_d.fresh = 1'b0;
        end else if (stall) begin
            ctrl_d.fresh = 1'b0;
        end else begin
            ctrl_d.valid     = in_valid;
            ctrl_d.fresh     = in_valid;
            ctrl_d.reg_write = in_reg_write;
            ctrl_d.wb_sel    = in_wb_sel;
            ctrl_d.funct3    = in_funct3;
            ctrl_d.rd_addr   = in_rd_addr;
            alu_d            = in_alu_result;
            mdata_d          = in_mem_rdata;
            pc_d             = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        ctrl_q  <= ctrl_d;
        alu_q   <= alu_d;
        mdata_q <= mdata_d;
        pc_q    <= pc_d;
        count_q <= count_d;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised and directed checks of mem_wb_stage against
// a byte-level reference model of the writeback rules.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd_addr;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_rdata;
    logic [63:0] in_pc;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        load_misaligned;
    logic [63:0] retired_count;

    int          n_vec;
    int          n_err;
    logic [63:0] exp_cnt;

    mem_wb_stage #(.XLEN(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_reg_write    (in_reg_write),
        .in_wb_sel       (in_wb_sel),
        .in_funct3       (in_funct3),
        .in_rd_addr      (in_rd_addr),
        .in_alu_result   (in_alu_result),
        .in_mem_rdata    (in_mem_rdata),
        .in_pc           (in_pc),
        .reg_write       (reg_write),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .load_misaligned (load_misaligned),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: assemble the load from individual bytes.
    function automatic void model(
        input  logic [1:0]  sel,
        input  logic [2:0]  f3,
        input  logic [63:0] alu,
        input  logic [63:0] rdata,
        input  logic [63:0] pc,
        output logic [63:0] d,
        output logic        mis
    );
        int off;
        int w;
        d   = 64'd0;
        mis = 1'b0;
        if (sel == 2'd0) d = alu;
        else if (sel == 2'd2) d = pc + 64'd4;
        else if (sel == 2'd1) begin
            off = int'(alu % 64'd8);
            case (f3)
                3'd0, 3'd4: w = 1;
                3'd1, 3'd5: w = 2;
                3'd2, 3'd6: w = 4;
                3'd3:       w = 8;
                default:    w = 0;
            endcase
            if (w == 0) mis = 1'b1;
            else begin
                mis = (off % w) != 0;
                for (int b = 0; b < w; b++)
                    if (off + b < 8)
                        d = d | (64'(rdata[8*(off+b) +: 8]) << (8*b));
                if (f3 < 3'd4 && w < 8 && d[8*w-1])
                    d = d | ~((64'd1 << (8*w)) - 64'd1);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(
        input logic        v,
        input logic        rw,
        input logic [1:0]  sel,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [63:0] alu,
        input logic [63:0] rdata,
        input logic [63:0] pc
    );
        in_valid      = v;
        in_reg_write  = rw;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_rd_addr    = rd;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_pc         = pc;
    endtask

    task automatic bubble();
        drive(0, 0, 2'd0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        bubble();
        tick(); tick();
        n_vec++;
        if (reg_write !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 64'd0
            || load_misaligned !== 1'b0 || retired_count !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rw=%b rd=%0d d=%h lm=%b cnt=%0d, want all 0",
                     reg_write, rd_addr, rd_data, load_misaligned, retired_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (reg_write !== 1'b0 || retired_count !== 64'd0) begin
                n_err++;
                $display("FAIL idle_after_reset: got rw=%b cnt=%0d, want 0/0",
                         reg_write, retired_count);
            end
        end
        exp_cnt = 64'd0;
    endtask

    task automatic test_loads();
        drive(1, 1, 2'd1, 3'd0, 5'd5, 64'h1003, 64'h0000_0000_8000_0000, 64'h400);
        tick();
        n_vec++;
        if (reg_write !== 1'b1 || rd_addr !== 5'd5
            || rd_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_err++;
            $display("FAIL lb: got rw=%b rd=%0d d=%h, want 1/5/ffffffffffffff80",
                     reg_write, rd_addr, rd_data);
        end
        exp_cnt++;
        drive(1, 1, 2'd1, 3'd4, 5'd5, 64'h1003, 64'h0000_0000_8000_0000, 64'h404);
        tick();
        n_vec++;
        if (reg_write !== 1'b1 || rd_data !== 64'h80) begin
            n_err++;
            $display("FAIL lbu: got rw=%b d=%h, want 1/80", reg_write, rd_data);
        end
        exp_cnt++;
        drive(1, 1, 2'd1, 3'd3, 5'd6, 64'h1000, 64'h0123_4567_89AB_CDEF, 64'h408);
        tick();
        n_vec++;
        if (reg_write !== 1'b1 || rd_data !== 64'h0123_4567_89AB_CDEF) begin
            n_err++;
            $display("FAIL ld: got rw=%b d=%h, want 1/0123456789abcdef",
                     reg_write, rd_data);
        end
        exp_cnt++;
        bubble();
        tick();
        n_vec++;
        if (reg_write !== 1'b0 || retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL loads_single_write: got rw=%b cnt=%0d, want 0/%0d",
                     reg_write, retired_count, exp_cnt);
        end
    endtask

    task automatic test_misaligned();
        drive(1, 1, 2'd1, 3'd2, 5'd9, 64'h1002, 64'h1111_2222_3333_4444, 64'h500);
        tick();
        n_vec++;
        if (reg_write !== 1'b0 || load_misaligned !== 1'b1) begin
            n_err++;
            $display("FAIL lw_misaligned: got rw=%b lm=%b, want 0/1",
                     reg_write, load_misaligned);
        end
        drive(1, 1, 2'd1, 3'd6, 5'd9, 64'h1004, 64'hDEAD_BEEF_0000_0000, 64'h504);
        tick();
        n_vec++;
        if (load_misaligned !== 1'b0 || retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL misaligned_pulse: got lm=%b cnt=%0d, want 0/%0d",
                     load_misaligned, retired_count, exp_cnt);
        end
        n_vec++;
        if (reg_write !== 1'b1 || rd_data !== 64'h0000_0000_DEAD_BEEF) begin
            n_err++;
            $display("FAIL lwu: got rw=%b d=%h, want 1/00000000deadbeef",
                     reg_write, rd_data);
        end
        exp_cnt++;
    endtask

    task automatic test_x0_and_jal();
        drive(1, 1, 2'd0, 3'd0, 5'd0, 64'd77, 64'd0, 64'h600);
        tick();
        n_vec++;
        if (reg_write !== 1'b0) begin
            n_err++;
            $display("FAIL x0_write: got rw=%b, want 0", reg_write);
        end
        exp_cnt++;
        drive(1, 1, 2'd2, 3'd0, 5'd1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        n_vec++;
        if (reg_write !== 1'b1 || rd_data !== 64'd0 || retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL jal_wrap: got rw=%b d=%h cnt=%0d, want 1/0/%0d",
                     reg_write, rd_data, retired_count, exp_cnt);
        end
        exp_cnt++;
    endtask

    task automatic test_stall_flush();
        int writes;
        drive(1, 1, 2'd0, 3'd0, 5'd7, 64'd42, 64'd0, 64'h700);
        tick();
        writes = reg_write ? 1 : 0;
        stall = 1'b1;
        drive(1, 1, 2'd0, 3'd0, 5'd8, 64'd99, 64'd0, 64'h704);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (reg_write) writes++;
            n_vec++;
            if (rd_data !== 64'd42 || rd_addr !== 5'd7) begin
                n_err++;
                $display("FAIL stall_hold: got d=%0d rd=%0d, want 42/7",
                         rd_data, rd_addr);
            end
        end
        exp_cnt++;
        n_vec++;
        if (writes != 1 || retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL stall_once: got writes=%0d cnt=%0d, want 1/%0d",
                     writes, retired_count, exp_cnt);
        end
        stall = 1'b0;
        drive(1, 1, 2'd0, 3'd0, 5'd3, 64'd5, 64'd0, 64'h710);
        tick();
        exp_cnt++;
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        bubble();
        n_vec++;
        if (reg_write !== 1'b0 || load_misaligned !== 1'b0) begin
            n_err++;
            $display("FAIL stall_flush: got rw=%b lm=%b, want 0/0",
                     reg_write, load_misaligned);
        end
        tick();
        n_vec++;
        if (retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL flush_count: got %0d, want %0d", retired_count, exp_cnt);
        end
        drive(1, 1, 2'd0, 3'd0, 5'd4, 64'd6, 64'd0, 64'h720);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        stall = 1'b0; rst = 1'b0;
        n_vec++;
        if (reg_write !== 1'b0 || retired_count !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mid_stall: got rw=%b cnt=%0d, want 0/0",
                     reg_write, retired_count);
        end
        exp_cnt = 64'd0;
    endtask

    task automatic test_random();
        logic        v, rw, mis, ew, elm;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] alu, rdata, pc, ed;
        for (int i = 0; i < 300; i++) begin
            v     = $urandom_range(0, 3) != 0;
            rw    = $urandom_range(0, 1) == 1;
            sel   = 2'($urandom);
            f3    = 3'($urandom);
            rd    = 5'($urandom);
            alu   = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            pc    = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) alu[2:0] = 3'd0;
            drive(v, rw, sel, f3, rd, alu, rdata, pc);
            tick();
            model(sel, f3, alu, rdata, pc, ed, mis);
            ew  = v && rw && (rd != 5'd0) && !mis;
            elm = v && mis;
            n_vec++;
            if (reg_write !== ew || load_misaligned !== elm || rd_addr !== rd
                || retired_count !== exp_cnt || (!mis && rd_data !== ed)) begin
                n_err++;
                $display("FAIL random_%0d: got rw=%b lm=%b rd=%0d d=%h cnt=%0d, want %b/%b/%0d/%h/%0d",
                         i, reg_write, load_misaligned, rd_addr, rd_data,
                         retired_count, ew, elm, rd, ed, exp_cnt);
            end
            if (v && !mis) exp_cnt++;
            stall = 1'b1;
            for (int s = $urandom_range(0, 2); s > 0; s--) begin
                drive(1'($urandom), 1, 2'($urandom), 3'($urandom), 5'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, 64'd0);
                tick();
                n_vec++;
                if (reg_write !== 1'b0 || load_misaligned !== 1'b0
                    || retired_count !== exp_cnt || (!mis && rd_data !== ed)) begin
                    n_err++;
                    $display("FAIL random_stall_%0d: got rw=%b lm=%b d=%h cnt=%0d, want 0/0/%h/%0d",
                             i, reg_write, load_misaligned, rd_data,
                             retired_count, ed, exp_cnt);
                end
            end
            stall = 1'b0;
        end
        bubble();
        tick();
        n_vec++;
        if (retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL random_count: got %0d, want %0d", retired_count, exp_cnt);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 64'd0;
        test_reset();
        test_loads();
        test_misaligned();
        test_x0_and_jal();
        test_stall_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the 64-bit RISC-V pipeline. It registers results leaving the memory stage, selects the writeback source (ALU, load data or link address), and sign- or zero-extends and aligns load data. It drives the register file write port (`reg_write`, `rd_addr`, `rd_data`) and keeps a retired-instruction counter.

## Interface

Parameters:
- `XLEN`, 64: datapath width.

Ports:
- `clk` in 1: clock. Regfile writes on posedge and reads on negedge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold stage contents.
- `flush` in 1: load a bubble.
- `in_valid` in 1: MEM stage holds a real instruction.
- `in_reg_write` in 1: instruction writes rd.
- `in_wb_sel` in 2: writeback source. 00 = ALU, 01 = MEM, 10 = PC+4, 11 = reserved (zero).
- `in_funct3` in 3: load width/sign.
- `in_rd_addr` in 5: destination register.
- `in_alu_result` in XLEN: ALU result, or load effective address.
- `in_mem_rdata` in XLEN: aligned 64-bit doubleword from data memory.
- `in_pc` in XLEN: instruction PC.
- `reg_write` out 1: regfile write enable.
- `rd_addr` out 5: regfile write address.
- `rd_data` out XLEN: regfile write data.
- `load_misaligned` out 1: one-cycle error pulse.
- `retired_count` out 64: instructions retired since reset.

## Operation

- Stage register fields: `valid`, `reg_write`, `wb_sel`, `funct3`, `rd_addr`, `alu_result`, `mem_rdata`, `pc`, and a one-bit `fresh`.
- Priority on each posedge is `rst`, then `flush`, then `stall`, then capture.
  - `rst`: all fields and `retired_count` cleared.
  - `flush`: `valid`=0 and `fresh`=0. Flush wins over a simultaneous stall.
  - `stall`: fields held; `fresh` cleared.
  - Otherwise: capture all inputs; `fresh`=`in_valid`.
- Load extension, indexed by `off` = `alu_result[2:0]`:
  - funct3 000 lb, 001 lh, 010 lw, 011 ld: sign-extend.
  - funct3 100 lbu, 101 lhu, 110 lwu: zero-extend.
  - funct3 111: result 0, flagged misaligned.
  - The selected field is `mem_rdata[8*off +: width]`.
- Misaligned when `wb_sel`=01 and any of: lh/lhu with `off[0]`≠0; lw/lwu with `off[1:0]`≠0; ld with `off`≠0; funct3 111.
- `rd_data`, combinational from stage regs:
  - 00: `alu_result`.
  - 01: extended load.
  - 10: `pc`+4, wrapping mod 2^XLEN.
  - 11: 0.
- `reg_write` = `valid` & `fresh` & `reg_write` & (`rd_addr`≠0) & !misaligned.
- `load_misaligned` = `valid` & `fresh` & misaligned.
- `retired_count` increments at posedge when `valid` & `fresh` & !misaligned. This holds even when rd = x0. It wraps at 2^64.

## Timing

- Reset values: every output is 0.
- Latency: inputs captured at posedge k. `reg_write`/`rd_data` are valid during cycle k to k+1. The regfile commits at posedge k+1, so the value is readable at the following negedge.
- Stall: `fresh` guarantees exactly one write and one count per instruction, whatever the stall length. `rd_data` stays stable throughout the stall.
- Reset asserted mid-stall or mid-write: the pending write is dropped. On the reset cycle `reg_write`=0 combinationally only after the clearing edge; the regfile's own `rst` has priority over the write on that same edge.
- Misaligned instruction: no write and no count. `load_misaligned` is high for exactly one cycle.

## Structure

- Package `wb_pkg`:
  - `WB_ALU`/`WB_MEM`/`WB_PC4` encodings.
  - `F3_LB`…`F3_LWU` constants.
  - Stage-register struct type.
- Sub-module `load_extend`: combinational; inputs `rdata`, `off`, `funct3`; outputs `data`, `misaligned`.
- Stage register, `fresh` logic, writeback mux and counter live in `mem_wb_stage`.

## Test plan

- Reset → all outputs 0.
  - Release reset, idle 3 cycles → `reg_write` stays 0 and `retired_count`=0.
- lb, addr 0x1003, rdata 0x0000_0000_8000_0000, rd=x5 → one-cycle write x5=0xFFFF_FFFF_FFFF_FF80.
  - Same with lbu → 0x80.
  - ld at 0x1000 → full doubleword.
- lw at addr 0x1002 → `reg_write`=0, `load_misaligned` high 1 cycle, count unchanged.
  - Then lwu 0x1004 with rdata upper word 0xDEADBEEF → x-reg = 0x0000_0000_DEAD_BEEF.
- ALU op with rd=x0, reg_write=1 → `reg_write`=0, `retired_count`+1.
- jal at pc 0xFFFF_FFFF_FFFF_FFFC, wb_sel=10, rd=x1 → `rd_data`=0.
- Capture ALU result 42 into x7, then hold `stall` 4 cycles → `reg_write` high exactly 1 cycle, count +1.
  - `stall`+`flush` together → next cycle `valid`=0, no write.
